// File: rtl/bcd_sevenseg_scanner_pkg.sv
// Shared constants for the BCD seven-segment scanner.
// Segment patterns are active-low, written g..a (bit 6 = g, bit 0 = a).
package bcd_sevenseg_scanner_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // A nibble outside 0..9 is not a valid BCD digit.
  function automatic logic nibble_invalid(input logic [3:0] n);
    return (n > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_sevenseg_scanner_bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd_i  [3:0]  BCD nibble; values A..F are shown as a dash
//   seg_o  [6:0]  active-low segments, bit 6 = g .. bit 0 = a
module bcd_to_7seg
  import bcd_sevenseg_scanner_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scanner.sv
// bcd_sevenseg_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display with optional leading-zero blanking.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   bcd_in    [15:0] packed BCD, [3:0] = digit 0 (units) .. [15:12] = digit 3
//   load      capture strobe: bcd_in enters the shadow register on every
//             rising edge where load=1 (no handshake, holding it high gives
//             a live pass-through)
//   blank_lz  blank zero digits above the most significant non-zero digit
//   seg       [6:0] registered active-low segments, bit 6 = g .. bit 0 = a
//   an        [3:0] registered active-low digit enables, one-hot-low
//   err       registered flag, high while any shadow nibble exceeds 9
module bcd_sevenseg_scanner
  import bcd_sevenseg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [6:0]                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic                       err_q, err_d;

  logic [3:0]            cur_digit;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] zero_from;  // digit i and all higher digits are zero
  logic                  all_hi_zero;
  logic                  blank_cur;

  assign cur_digit = shadow_q[idx_q];

  bcd_to_7seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    shadow_d    = shadow_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    zero_from   = '0;
    all_hi_zero = 1'b1;
    err_d       = 1'b0;

    if (load) begin
      shadow_d = bcd_in;
    end

    // Refresh counter wraps at REFRESH_DIV-1; the scan index steps on the wrap.
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end

    // Walk from the most significant digit down, accumulating "all zero so far".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_hi_zero  = all_hi_zero & (shadow_q[i] == 4'd0);
      zero_from[i] = all_hi_zero;
    end

    // Units digit is always shown so a zero value still displays "0".
    blank_cur = blank_lz && (idx_q != '0) && zero_from[idx_q];

    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = blank_cur ? SEG_OFF : dec_seg;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      err_d = err_d | nibble_invalid(shadow_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= '1;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      err_q    <= err_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Directed bench for bcd_sevenseg_scanner with an expected-value queue.
module tb_bcd_sevenseg_scanner;

  localparam int DIV = 4;

  logic        clk;
  logic        reset;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {an, seg, err} per clock edge.
  logic [11:0] exp_q[$];

  // Reference picture of the display as the spec describes it.
  logic [15:0] m_shadow;
  int          m_cyc;
  logic [6:0]  dec_tab [10];

  bcd_sevenseg_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .bcd_in   (bcd_in),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .err      (err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference helpers ----------------
  function automatic logic [6:0] ref_seg(input logic [15:0] sh, input int d,
                                         input logic blank);
    logic [3:0]  nib;
    logic [15:0] hi;
    nib = sh[d*4 +: 4];
    hi  = sh >> (d * 4);
    if (blank && d != 0 && hi == 16'h0) return 7'b1111111;
    if (nib > 4'd9) return 7'b0111111;
    return dec_tab[nib];
  endfunction

  function automatic logic ref_err(input logic [15:0] sh);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++) e = e | (sh[i*4 +: 4] > 4'd9);
    return e;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge: push what the display must show after it, then compare.
  task automatic tick(input string tag);
    int         d;
    logic [3:0] an_e;
    logic [11:0] e;
    d    = (m_cyc / DIV) % 4;
    an_e = ~(4'b0001 << d);
    exp_q.push_back({an_e, ref_seg(m_shadow, d, blank_lz), ref_err(m_shadow)});
    if (load) m_shadow = bcd_in;
    @(posedge clk);
    m_cyc++;
    #1;
    e = exp_q.pop_front();
    check({tag, "_an"},  {3'b000, an},  {3'b000, e[11:8]});
    check({tag, "_seg"}, seg,           e[7:1]);
    check({tag, "_err"}, {6'b0, err},   {6'b0, e[0]});
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic load_value(input logic [15:0] v, input string tag);
    bcd_in = v;
    load   = 1'b1;
    tick(tag);
    load   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  {3'b000, an}, 7'b0001111);
    check({tag, "_seg"}, seg,          7'b1111111);
    check({tag, "_err"}, {6'b0, err},  7'b0000000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    reset    = 1'b1;
    bcd_in   = 16'h0;
    load     = 1'b0;
    blank_lz = 1'b0;
    m_shadow = 16'h0;
    m_cyc    = 0;

    // Reset values hold while reset is asserted.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    reset = 1'b0;

    // Blank shadow: full scan 1110/1101/1011/0111 then 1110 again, all '0'.
    ticks(20, "scan_zero");

    // Load 1234 mid-scan, observe every digit.
    ticks(3, "pre_1234");
    load_value(16'h1234, "load_1234");
    ticks(18, "show_1234");

    // Leading-zero blanking on 0047, then switched off mid-frame.
    blank_lz = 1'b1;
    load_value(16'h0047, "load_0047");
    ticks(17, "blank_0047");
    blank_lz = 1'b0;
    ticks(17, "noblank_0047");

    // All-zero value with blanking: only the units digit shows.
    blank_lz = 1'b1;
    load_value(16'h0000, "load_0000");
    ticks(17, "blank_0000");

    // Invalid nibble raises err and shows a dash; cleared by a valid load.
    blank_lz = 1'b0;
    load_value(16'h00A5, "load_00a5");
    ticks(17, "show_00a5");
    load_value(16'h0005, "load_0005");
    ticks(5, "clear_err");

    // A few random values, blanking chosen at random.
    for (int k = 0; k < 4; k++) begin
      blank_lz = 1'($urandom_range(0, 1));
      load_value(16'($urandom_range(0, 65535)), "load_rand");
      ticks(16 + $urandom_range(0, 3), "show_rand");
    end

    // Live pass-through: load held high, units digit from an up/down counter.
    blank_lz = 1'b1;
    load     = 1'b1;
    cnt      = 7;
    for (int i = 0; i < 40; i++) begin
      bcd_in = {12'h300, 4'(cnt)};
      tick("count_up");
      cnt = (cnt == 9) ? 0 : cnt + 1;
    end
    for (int i = 0; i < 37; i++) begin
      bcd_in = {12'h000, 4'(cnt)};
      tick("count_down");
      cnt = (cnt == 0) ? 9 : cnt - 1;
    end

    // Reset mid-frame blanks the display at once, without a clock edge.
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    load     = 1'b0;
    blank_lz = 1'b0;
    m_shadow = 16'h0;
    m_cyc    = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_hold");
    reset = 1'b0;
    ticks(18, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_scanner.md
BCD_SEVENSEG_SCANNER -- requirements
Module: bcd_sevenseg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 4, clock cycles each digit stays enabled; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 bcd_in  input  16  packed BCD digits; [3:0] is digit 0 (units) and [15:12] is digit 3; digit 0 is fed from the up/down counter's count.
REQ-005 load  input  1  when high at a rising edge, bcd_in is captured into the shadow register.
REQ-006 blank_lz  input  1  leading-zero blanking enable.
REQ-007 seg  output  7  active-low segments; seg[0]=a … seg[6]=g; registered.
REQ-008 an  output  4  active-low digit enables, one-hot-low; an[i] drives digit i; registered.
REQ-009 err  output  1  high while any shadow nibble exceeds 9; registered.

Function
REQ-010 The shadow register shall update only at edges where load=1; while load=0 it shall hold its value.
REQ-011 The refresh counter shall count 0..REFRESH_DIV-1 and wrap to 0; at its terminal count, scan index idx shall advance 0→1→2→3→0.
REQ-012 Each edge, an shall be registered as ~(1<<idx) and seg as the decode of shadow digit idx; the outputs therefore lag idx/shadow by one cycle.
REQ-013 Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (bit order g..a).
REQ-014 Nibbles A–F shall decode to a dash: seg=0111111, only g lit.
REQ-015 With blank_lz=1, digit i (i=1..3) shall be blanked (seg=1111111) when digit i and every higher digit are zero; digit 0 shall never be blanked.
REQ-016 Blanking shall not alter an; the scan continues unchanged.
REQ-017 The next value of err shall be the OR over the four shadow nibbles of (nibble > 9).
REQ-018 A load arriving mid-scan shall not disturb idx or the refresh counter; the new value shall reach seg one edge after capture, if that digit is being scanned.
REQ-019 load held high continuously shall capture every cycle, allowing a live pass-through of the counter.
REQ-020 A change on blank_lz shall take effect on seg at the next edge.

Reset
REQ-021 While reset=1: shadow=0, idx=0, refresh counter=0, an=1111, seg=1111111, err=0, all applied asynchronously.
REQ-022 At the first edge after reset deasserts: an=1110 and seg=1000000 (digit '0').
REQ-023 Reset asserted mid-frame shall blank the display immediately, with no partial digit retained.

Structure
REQ-024 A shared package shall hold the segment constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and the digit-count constant NUM_DIGITS=4.
REQ-025 The combinational decode shall be a sub-module bcd_to_7seg (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.
REQ-026 The refresh counter width shall be $clog2(REFRESH_DIV).

Verification
REQ-027 Reset, then run 16 cycles with REFRESH_DIV=4 and shadow 0 → an = 1110, 1101, 1011, 0111, each held 4 cycles, then 1110 again; seg=1000000 throughout.
REQ-028 load with bcd_in=16'h1234 → while an=1110, seg=0011001 ('4'); an=1101 gives 0110000; an=1011 gives 0100100; an=0111 gives 1111001; err=0.
REQ-029 bcd_in=16'h0047, blank_lz=1 → digits 3 and 2 give seg=1111111, digit 1 gives 0011001, digit 0 gives 1111000; with blank_lz=0, digits 3 and 2 give 1000000.
REQ-030 bcd_in=16'h0000, blank_lz=1 → digits 3..1 blank and digit 0 shows 1000000.
REQ-031 bcd_in=16'h00A5 → digit 1 gives seg=0111111 and err=1 one edge after load; then load 16'h0005 → err=0 at the following edge.
REQ-032 Hold load=1 with digit 0 driven by an up/down counter wrapping 9→0 and 0→9, and assert reset mid-frame → digit 0 follows the count one edge later; on reset, an=1111 and seg=1111111 immediately.
